// File: rtl/iq_fir_scheduler_if.sv
// I/Q sample and filtered-output bundle for iq_fir_scheduler.
// master drives run enable and samples; slave returns the filtered pair and status.
`timescale 1ns/1ps
interface iq_fir_scheduler_if #(
    parameter int DATA_WIDTH = 16
);
    logic                         start;
    logic signed [DATA_WIDTH-1:0] sample_i;
    logic signed [DATA_WIDTH-1:0] sample_q;
    logic signed [DATA_WIDTH-1:0] out_i;
    logic signed [DATA_WIDTH-1:0] out_q;
    logic                         out_valid;
    logic                         busy;
    logic                         overrun;

    modport master (
        output start, sample_i, sample_q,
        input  out_i, out_q, out_valid, busy, overrun
    );

    modport slave (
        input  start, sample_i, sample_q,
        output out_i, out_q, out_valid, busy, overrun
    );
endinterface

// File: rtl/iq_fir_scheduler.sv
// Shared-MAC 16-tap Hamming low-pass for I then Q, one pair per decimated tick.
// Define FIR_SYMMETRIC_EN to fold symmetric taps with a pre-add (half the MAC cycles).
`timescale 1ns/1ps
module iq_fir_scheduler #(
    parameter int TAPS         = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int SYS_CLK_FREQ = 6400_000,
    parameter int SAMPLE_RATE  = 800
) (
    input  logic              clk,
    input  logic              rst,
    iq_fir_scheduler_if.slave bus
);
    localparam int SAMPLE_DIV = SYS_CLK_FREQ / SAMPLE_RATE;
    localparam int KW         = $clog2(TAPS);
    localparam int AW         = 2 * DATA_WIDTH + 2;
`ifdef FIR_SYMMETRIC_EN
    localparam int MAC_STEPS  = TAPS / 2;
    localparam int OPW        = DATA_WIDTH + 1;
`else
    localparam int MAC_STEPS  = TAPS;
    localparam int OPW        = DATA_WIDTH;
`endif
    localparam int PW         = OPW + DATA_WIDTH;
    localparam logic [KW-1:0] K_LAST = KW'(MAC_STEPS - 1);

    typedef enum logic [2:0] {IDLE, MAC_I, STORE_I, MAC_Q, STORE_Q} state_t;

    state_t                       state_reg;
    logic [31:0]                  cnt_reg;
    logic [KW-1:0]                k_reg;
    logic signed [AW-1:0]         acc_reg;
    logic signed [AW-1:0]         acc_next;
    logic signed [DATA_WIDTH-1:0] dl_i_reg  [TAPS];
    logic signed [DATA_WIDTH-1:0] dl_q_reg  [TAPS];
    logic signed [DATA_WIDTH-1:0] dl_i_next [TAPS];
    logic signed [DATA_WIDTH-1:0] dl_q_next [TAPS];
    logic signed [DATA_WIDTH-1:0] out_i_reg;
    logic signed [DATA_WIDTH-1:0] out_q_reg;
    logic                         out_valid_reg;
    logic                         busy_reg;
    logic                         overrun_reg;
    logic                         tick;
    logic                         shift_en;
    logic signed [OPW-1:0]        op_sel;
    logic signed [DATA_WIDTH-1:0] coef_sel;
    logic signed [PW-1:0]         prod;

    // Hamming low-pass, mirrored about the centre of the 16-tap window
    function automatic logic signed [DATA_WIDTH-1:0] coef(input logic [KW-1:0] k);
        case (int'(k))
            0, 15:   coef = DATA_WIDTH'(173);
            1, 14:   coef = DATA_WIDTH'(288);
            2, 13:   coef = DATA_WIDTH'(548);
            3, 12:   coef = DATA_WIDTH'(1001);
            4, 11:   coef = DATA_WIDTH'(1691);
            5, 10:   coef = DATA_WIDTH'(2633);
            6, 9:    coef = DATA_WIDTH'(3787);
            7, 8:    coef = DATA_WIDTH'(5053);
            default: coef = '0;
        endcase
    endfunction

    assign tick     = bus.start && (cnt_reg == 32'(SAMPLE_DIV - 1));
    assign shift_en = tick && (state_reg == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_reg <= '0;
        else if (!bus.start || tick)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_reg + 32'd1;
    end

    for (genvar gi = 0; gi < TAPS; gi++) begin : g_dl
        if (gi == 0) begin : g_head
            assign dl_i_next[gi] = bus.sample_i;
            assign dl_q_next[gi] = bus.sample_q;
        end else begin : g_tail
            assign dl_i_next[gi] = dl_i_reg[gi-1];
            assign dl_q_next[gi] = dl_q_reg[gi-1];
        end
    end

    // Ticks that land mid-computation leave the delay lines alone
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dl_i_reg <= '{default: '0};
            dl_q_reg <= '{default: '0};
        end else if (shift_en) begin
            dl_i_reg <= dl_i_next;
            dl_q_reg <= dl_q_next;
        end
    end

`ifdef FIR_SYMMETRIC_EN
    logic [KW-1:0] k_mirror;
    assign k_mirror = KW'(TAPS - 1) - k_reg;

    always_comb begin
        op_sel = '0;
        if (state_reg == MAC_Q)
            op_sel = {dl_q_reg[k_reg][DATA_WIDTH-1], dl_q_reg[k_reg]}
                   + {dl_q_reg[k_mirror][DATA_WIDTH-1], dl_q_reg[k_mirror]};
        else
            op_sel = {dl_i_reg[k_reg][DATA_WIDTH-1], dl_i_reg[k_reg]}
                   + {dl_i_reg[k_mirror][DATA_WIDTH-1], dl_i_reg[k_mirror]};
    end
`else
    always_comb begin
        op_sel = '0;
        if (state_reg == MAC_Q)
            op_sel = dl_q_reg[k_reg];
        else
            op_sel = dl_i_reg[k_reg];
    end
`endif

    assign coef_sel = coef(k_reg);
    assign prod     = PW'(op_sel) * PW'(coef_sel);
    assign acc_next = acc_reg + AW'(prod);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            k_reg         <= '0;
            acc_reg       <= '0;
            out_i_reg     <= '0;
            out_q_reg     <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            if (tick && state_reg != IDLE)
                overrun_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (tick) begin
                        acc_reg   <= '0;
                        k_reg     <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= MAC_I;
                    end
                end
                MAC_I: begin
                    acc_reg <= acc_next;
                    k_reg   <= k_reg + KW'(1);
                    if (k_reg == K_LAST)
                        state_reg <= STORE_I;
                end
                STORE_I: begin
                    out_i_reg <= acc_reg[2*DATA_WIDTH:DATA_WIDTH+1];
                    acc_reg   <= '0;
                    k_reg     <= '0;
                    state_reg <= MAC_Q;
                end
                MAC_Q: begin
                    acc_reg <= acc_next;
                    k_reg   <= k_reg + KW'(1);
                    if (k_reg == K_LAST)
                        state_reg <= STORE_Q;
                end
                STORE_Q: begin
                    out_q_reg     <= acc_reg[2*DATA_WIDTH:DATA_WIDTH+1];
                    out_valid_reg <= 1'b1;
                    busy_reg      <= 1'b0;
                    state_reg     <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.out_i     = out_i_reg;
    assign bus.out_q     = out_q_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.busy      = busy_reg;
    assign bus.overrun   = overrun_reg;
endmodule

// File: tb/tb_iq_fir_scheduler.sv
// Self-checking bench for iq_fir_scheduler: table-driven vectors with a scoreboard,
// plus hand sequences for latency, start drop, mid-computation reset and overrun.
`timescale 1ns/1ps
module tb_iq_fir_scheduler;
    localparam int DIV_A = 40;
    localparam int DIV_B = 20;
    localparam int NVEC  = 43;
`ifdef FIR_SYMMETRIC_EN
    localparam int LAT     = 18;
    localparam int OVR_EXP = 0;
`else
    localparam int LAT     = 34;
    localparam int OVR_EXP = 1;
`endif

    typedef struct {
        logic signed [15:0] si;
        logic signed [15:0] sq;
        int                 ei;
        int                 eq;
    } vec_t;

    typedef struct {
        int i;
        int q;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    iq_fir_scheduler_if #(.DATA_WIDTH(16)) a ();
    iq_fir_scheduler_if #(.DATA_WIDTH(16)) b ();

    iq_fir_scheduler #(.TAPS(16), .DATA_WIDTH(16), .SYS_CLK_FREQ(32000), .SAMPLE_RATE(800))
        dut_a (.clk(clk), .rst(rst_n), .bus(a));
    iq_fir_scheduler #(.TAPS(16), .DATA_WIDTH(16), .SYS_CLK_FREQ(16000), .SAMPLE_RATE(800))
        dut_b (.clk(clk), .rst(rst_n), .bus(b));

    int   h_tab [16] = '{173, 288, 548, 1001, 1691, 2633, 3787, 5053,
                         5053, 3787, 2633, 1691, 1001, 548, 288, 173};
    int   hist_i [16];
    int   hist_q [16];
    exp_t sb_q [$];
    vec_t vecs [NVEC];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   got_i [64];
    int   got_q [64];
    int   n_valid  = 0;
    logic prev_valid_a = 1'b0;
    int   cnt_a = 0;
    int   cnt_b = 0;

    // Bench-side tick timing for each instance
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a <= 0;
            cnt_b <= 0;
        end else begin
            cnt_a <= (!a.start || cnt_a == DIV_A - 1) ? 0 : cnt_a + 1;
            cnt_b <= (!b.start || cnt_b == DIV_B - 1) ? 0 : cnt_b + 1;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    function automatic int scale(input longint acc);
        logic signed [15:0] r;
        r = 16'(acc >>> 17);
        return int'(r);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 16; k++) begin
            hist_i[k] = 0;
            hist_q[k] = 0;
        end
    endtask

    task automatic model_push(input int si, input int sq, output int ei, output int eq);
        longint ai;
        longint aq;
        for (int k = 15; k > 0; k--) begin
            hist_i[k] = hist_i[k-1];
            hist_q[k] = hist_q[k-1];
        end
        hist_i[0] = si;
        hist_q[0] = sq;
        ai = 0;
        aq = 0;
        for (int k = 0; k < 16; k++) begin
            ai += longint'(h_tab[k]) * longint'(hist_i[k]);
            aq += longint'(h_tab[k]) * longint'(hist_q[k]);
        end
        ei = scale(ai);
        eq = scale(aq);
    endtask

    task automatic push_exp(input int ei, input int eq);
        exp_t e;
        e.i = ei;
        e.q = eq;
        sb_q.push_back(e);
    endtask

    task automatic drive_tick_a(input logic signed [15:0] si, input logic signed [15:0] sq);
        int guard = 0;
        @(negedge clk);
        a.sample_i = si;
        a.sample_q = sq;
        while (cnt_a != DIV_A - 1 && guard < 4 * DIV_A) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 4 * DIV_A) begin
            $display("FAIL tick_wait_a: got no tick within %0d cycles, expected one", guard);
            $fatal(1, "tick wait expired");
        end
        @(posedge clk);
    endtask

    task automatic drive_tick_b(input logic signed [15:0] si, input logic signed [15:0] sq);
        int guard = 0;
        @(negedge clk);
        b.sample_i = si;
        b.sample_q = sq;
        while (cnt_b != DIV_B - 1 && guard < 4 * DIV_B) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 4 * DIV_B) begin
            $display("FAIL tick_wait_b: got no tick within %0d cycles, expected one", guard);
            $fatal(1, "tick wait expired");
        end
        @(posedge clk);
    endtask

    // Counts edges after the tick edge until out_valid is seen (bounded)
    task automatic wait_valid_a(input int n0, output int n, output int busy_v);
        bit seen = 0;
        n = n0;
        busy_v = -1;
        while (!seen && n < 100) begin
            @(negedge clk);
            if (a.out_valid) begin
                seen = 1;
                busy_v = int'(a.busy);
            end else begin
                @(posedge clk);
                n++;
            end
        end
        if (!seen) n = -1;
    endtask

    task automatic check_zero_a(input string tag);
        check({tag, "_out_i"},     int'(a.out_i),     0);
        check({tag, "_out_q"},     int'(a.out_q),     0);
        check({tag, "_out_valid"}, int'(a.out_valid), 0);
        check({tag, "_busy"},      int'(a.busy),      0);
        check({tag, "_overrun"},   int'(a.overrun),   0);
    endtask

    // Scoreboard consumer: one line per output transaction
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid_a <= 1'b0;
        end else begin
            if (a.out_valid) begin
                check("valid_pulse", int'(prev_valid_a), 0);
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_valid: got out_valid with out_i=%0d out_q=%0d, expected no transaction",
                             a.out_i, a.out_q);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    $display("txn %0d: out_i=%0d out_q=%0d (expect %0d %0d)",
                             n_valid, a.out_i, a.out_q, e.i, e.q);
                    check("out_i", int'(a.out_i), e.i);
                    check("out_q", int'(a.out_q), e.q);
                end
                if (n_valid < 64) begin
                    got_i[n_valid] = int'(a.out_i);
                    got_q[n_valid] = int'(a.out_q);
                end
                n_valid++;
            end
            prev_valid_a <= a.out_valid;
        end
    end

    initial begin
        int n;
        int bv;
        int ei;
        int eq;
        int cnt;
        longint ai;
        longint aq;

        model_reset();
        for (int v = 0; v < NVEC; v++) begin
            if (v == 0) begin
                vecs[v].si = 16'sd32767;
                vecs[v].sq = 16'sd0;
            end else if (v <= 16) begin
                vecs[v].si = 16'sd0;
                vecs[v].sq = 16'sd0;
            end else if (v <= 34) begin
                vecs[v].si = 16'sd32767;
                vecs[v].sq = -16'sd32768;
            end else begin
                vecs[v].si = 16'($urandom);
                vecs[v].sq = 16'($urandom);
            end
            model_push(int'(vecs[v].si), int'(vecs[v].sq), vecs[v].ei, vecs[v].eq);
        end

        a.start = 1'b0; a.sample_i = '0; a.sample_q = '0;
        b.start = 1'b0; b.sample_i = '0; b.sample_q = '0;
        repeat (3) @(negedge clk);
        check_zero_a("reset");
        rst_n   = 1'b1;
        a.start = 1'b1;

        for (int v = 0; v < NVEC; v++) begin
            push_exp(vecs[v].ei, vecs[v].eq);
            drive_tick_a(vecs[v].si, vecs[v].sq);
        end
        cnt = 0;
        while (sb_q.size() != 0 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("table_drain", sb_q.size(), 0);

        check("impulse_first", got_i[0], 43);
        check("impulse_eighth", got_i[7], 1263);
        check("impulse_q", got_q[3], 0);
        check("dc_i", got_i[32], 7586);
        check("dc_q", got_q[32], -7587);
        check("dc_i_steady", got_i[34], 7586);

        model_push(12000, -9000, ei, eq);
        push_exp(ei, eq);
        drive_tick_a(16'sd12000, -16'sd9000);
        wait_valid_a(0, n, bv);
        check("latency", n, LAT);
        check("busy_at_valid", bv, 0);
        @(negedge clk);
        check("valid_width", int'(a.out_valid), 0);

        model_push(20000, 15000, ei, eq);
        push_exp(ei, eq);
        drive_tick_a(16'sd20000, 16'sd15000);
        repeat (5) @(posedge clk);
        #1 a.start = 1'b0;
        wait_valid_a(5, n, bv);
        check("stop_latency", n, LAT);
        cnt = 0;
        repeat (3 * DIV_A) begin
            @(negedge clk);
            if (a.busy) cnt++;
        end
        check("stop_no_tick", cnt, 0);

        a.start = 1'b1;
        drive_tick_a(-16'sd25000, 16'sd31000);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_zero_a("mid_reset");
        sb_q.delete();
        model_reset();
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        a.start = 1'b0;
        cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (a.out_valid) cnt++;
        end
        check("reset_no_valid", cnt, 0);

        check("ovr_initial", int'(b.overrun), 0);
        b.start = 1'b1;
        drive_tick_b(16'sd32767, -16'sd20000);
        #1 check("ovr_tick1", int'(b.overrun), 0);
        check("ovr_busy", int'(b.busy), 1);
        drive_tick_b(-16'sd32768, 16'sd12345);
        #1 check("ovr_tick2", int'(b.overrun), OVR_EXP);
        drive_tick_b(16'sd16384, -16'sd16384);
`ifdef FIR_SYMMETRIC_EN
        ai = longint'(h_tab[0]) * 16384 + longint'(h_tab[1]) * (-32768) + longint'(h_tab[2]) * 32767;
        aq = longint'(h_tab[0]) * (-16384) + longint'(h_tab[1]) * 12345 + longint'(h_tab[2]) * (-20000);
`else
        ai = longint'(h_tab[0]) * 16384 + longint'(h_tab[1]) * 32767;
        aq = longint'(h_tab[0]) * (-16384) + longint'(h_tab[1]) * (-20000);
`endif
        cnt = 0;
        @(negedge clk);
        while (!b.out_valid && cnt < 60) begin
            @(negedge clk);
            cnt++;
        end
        check("ovr_valid_seen", int'(b.out_valid), 1);
        $display("txn b: out_i=%0d out_q=%0d (expect %0d %0d)", b.out_i, b.out_q, scale(ai), scale(aq));
        check("ovr_out_i", int'(b.out_i), scale(ai));
        check("ovr_out_q", int'(b.out_q), scale(aq));
        repeat (50) @(negedge clk);
        check("ovr_sticky", int'(b.overrun), OVR_EXP);
        b.start = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
